jtopll_wrsched: RTL and testbench
=================================

// Module: jtopll_wrsched
// PURPOSE
// CPU write scheduler for the OPLL register block. Latches the register address, queues data writes,
// decodes them into the register block's update strobes (sel_group/sel_sub/up_*) and holds each
// channel-level strobe for one full 18-slot pipeline round, so the write lands whatever slot is active.
// Sits between the CPU bus and the register block; also owns the rhythm register (0x0E).
// PARAMETERS
// FIFO_AW    2    log2 of write-queue depth (4 entries)
// APPLY_LEN  18   cen ticks a channel strobe is held (one full slot round)
// PORTS
// clk          in   1  system clock
// rst          in   1  synchronous reset, active-high
// cen          in   1  clock enable, one pulse per slot
// addr         in   1  0: address port, 1: data port
// din          in   8  CPU write data
// wr           in   1  CPU write strobe, one clk wide, sampled regardless of cen
// busy         out  1  queue non-empty or apply in progress
// ovf          out  1  sticky: data write dropped because queue was full
// zero         in   1  slot-counter zero flag from register block
// reg_din      out  8  data presented to register block
// sel_group    out  2  target group (channel/3)
// sel_sub      out  3  target subslot (channel%3, or patch byte index 0-7)
// up_fnumlo/up_fnumhi/up_inst/up_original  out 1 each  update strobes
// rhy_en       out  1  rhythm mode enable (reg 0x0E bit 5)
// rhy_kon      out  5  rhythm key-on (reg 0x0E bits 4:0)
// BEHAVIOUR
// - Reset: all outputs 0, address latch 0, queue empty, state IDLE, ovf 0.
// - wr&&!addr: address latch <= din next clk. wr&&addr: push {latch,din}; full -> drop, ovf<=1.
// - Push and pop in the same clk both take effect; count unchanged.
// - Decode (header jtopll_regmap.vh): 00-07 patch byte; 0E rhythm; 10-18 fnumlo; 20-28 fnumhi;
//   30-38 inst/vol; all else (incl. 0F, 19-1F, x9-xF) popped and discarded in one clk, no strobe.
// - FSM IDLE -> (queue non-empty) POP: head to reg_din/sel_*; decode class:
//   * patch: up_original high exactly 1 clk (sel_sub=addr[2:0]), -> IDLE.
//   * rhythm: rhy_en/rhy_kon updated 1 clk after POP, -> IDLE; no strobe.
//   * channel: -> WAIT_ZERO. On cen&&zero -> APPLY, cnt<=0; up_* high from next clk.
//   * APPLY: cnt++ on each cen; after APPLY_LEN cen ticks strobe drops same clk, -> IDLE.
// - Channel c: sel_group=c/3, sel_sub=c%3. reg_din/sel_* stable for the whole strobe.
// - Exactly one up_* high at any time. Worst-case channel latency 2*APPLY_LEN cen + 3 clk.
// - cen low: WAIT_ZERO/APPLY frozen; patch/rhythm/discard still complete (not cen-gated).
// - Writes arriving during APPLY queue; they never alter the in-flight reg_din/sel_*.
// - Reset mid-APPLY: strobe low next edge, queue flushed, rhy_* cleared.
// - busy = (state!=IDLE) | !empty; ovf cleared only by rst.
// STRUCTURE
// - jtopll_regmap.vh: address range localparams, class codes, FSM state encodings.
// - Sub-module jtopll_wrfifo: synchronous FIFO, WIDTH=16, AW=FIFO_AW, push/pop/full/empty.
// - Top: address latch, decoder, FSM, cen counter, rhythm register.
// TESTING
// - addr<=0x10, data 0xAB -> after next zero: up_fnumlo high 18 cen, sel_group=0, sel_sub=0, reg_din=0xAB.
// - addr 0x27 data 0x15 -> sel_group=2, sel_sub=1, up_fnumhi for exactly 18 cen ticks after zero.
// - addr 0x0E data 0x3F -> rhy_en=1, rhy_kon=1F in 2 clk, no up_* strobe; 0x05 data 0x77 -> up_original 1 clk, sel_sub=5.
// - 5 back-to-back data writes during APPLY -> 4 queued, ovf=1, applied in order, busy falls after last.
// - Write to 0x19 and 0x0F -> discarded, no strobe, busy drops within 2 clk.
// - rst pulse mid-APPLY -> all up_* 0 next edge, busy=0, ovf=0, rhy_en=0.

Source files
------------

// File: rtl/jtopll_wrsched_pkg.sv
// jtopll_wrsched_pkg: OPLL register map decode, strobe classes and scheduler FSM states
package jtopll_wrsched_pkg;
  localparam logic [7:0] A_RHY = 8'h0E;
  localparam logic [3:0] CH_LAST = 4'd8;
  typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_WAIT, ST_APPLY} st_e;
  typedef enum logic [2:0] {CL_NONE, CL_PATCH, CL_RHY, CL_FLO, CL_FHI, CL_INST} cls_e;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  function automatic cls_e decode(input logic [7:0] a);
    return a[7:3] == 5'd0 ? CL_PATCH :
           a == A_RHY ? CL_RHY :
           (a[3:0] > CH_LAST || a[7:6] != 2'd0) ? CL_NONE :
           a[5:4] == 2'd1 ? CL_FLO :
           a[5:4] == 2'd2 ? CL_FHI :
           a[5:4] == 2'd3 ? CL_INST : CL_NONE;
  endfunction
  // strobe mask order: {up_original, up_inst, up_fnumhi, up_fnumlo}
  function automatic logic [3:0] up_mask(input cls_e c);
    return c == CL_FLO ? 4'b0001 : c == CL_FHI ? 4'b0010 :
           c == CL_INST ? 4'b0100 : c == CL_PATCH ? 4'b1000 : 4'b0000;
  endfunction
  function automatic logic [1:0] ch_grp(input logic [3:0] c);
    return c >= 4'd6 ? 2'd2 : c >= 4'd3 ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [2:0] ch_sub(input logic [3:0] c);
    return 3'(c >= 4'd6 ? c - 4'd6 : c >= 4'd3 ? c - 4'd3 : c);
  endfunction
endpackage

// File: rtl/jtopll_wrfifo.sv
// jtopll_wrfifo: synchronous FIFO; a push into a full FIFO is ignored
module jtopll_wrfifo #(
  parameter int WIDTH = 16,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  assign full = r_cnt[AW];
  assign empty = r_cnt == '0;
  assign dout = r_mem[r_rp];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/jtopll_wrsched.sv
// jtopll_wrsched: queues CPU writes and turns them into register-block update strobes,
// holding channel strobes for a full slot round; also owns the rhythm register.
module jtopll_wrsched
  import jtopll_wrsched_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int APPLY_LEN = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       addr,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       busy,
  output logic       ovf,
  input  logic       zero,
  output logic [7:0] reg_din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_original,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);
  localparam int CW = $clog2(APPLY_LEN);
  localparam logic [CW-1:0] LAST = CW'(APPLY_LEN - 1);
  st_e r_st;
  cls_e w_cls;
  wr_t w_head;
  logic [7:0] r_alatch, r_din;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_up, r_mask, w_ch;
  logic [1:0] r_grp;
  logic [2:0] r_sub;
  logic [4:0] r_rhy_kon;
  logic r_ovf, r_rhy_en, w_push, w_pop, w_full, w_empty;
  assign w_push = wr && addr;
  assign w_pop = r_st == ST_POP;
  assign w_cls = decode(w_head.a);
  assign w_ch = w_head.a[3:0];
  jtopll_wrfifo #(.WIDTH(16), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .din({r_alatch, din}),
    .dout(w_head),
    .full(w_full),
    .empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alatch <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (wr && !addr) r_alatch <= din;
      if (w_push && w_full) r_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= ST_IDLE;
      r_up <= '0;
      r_mask <= '0;
      r_cnt <= '0;
      r_din <= '0;
      r_grp <= '0;
      r_sub <= '0;
      r_rhy_en <= 1'b0;
      r_rhy_kon <= '0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          r_up <= '0;
          if (!w_empty) r_st <= ST_POP;
        end
        ST_POP: begin
          r_din <= w_head.d;
          r_grp <= w_cls == CL_PATCH ? 2'd0 : ch_grp(w_ch);
          r_sub <= w_cls == CL_PATCH ? w_head.a[2:0] : ch_sub(w_ch);
          r_mask <= up_mask(w_cls);
          r_up <= w_cls == CL_PATCH ? up_mask(CL_PATCH) : 4'b0000;
          if (w_cls == CL_RHY) {r_rhy_en, r_rhy_kon} <= w_head.d[5:0];
          r_st <= w_cls inside {CL_FLO, CL_FHI, CL_INST} ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT:
          if (cen && zero) begin
            r_st <= ST_APPLY;
            r_cnt <= '0;
            r_up <= r_mask;
          end
        ST_APPLY:
          if (cen) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_up <= '0;
              r_st <= ST_IDLE;
            end
          end
        default: r_st <= ST_IDLE;
      endcase
    end
  end
  assign busy = r_st != ST_IDLE || !w_empty;
  assign ovf = r_ovf;
  assign reg_din = r_din;
  assign sel_group = r_grp;
  assign sel_sub = r_sub;
  assign {up_original, up_inst, up_fnumhi, up_fnumlo} = r_up;
  assign rhy_en = r_rhy_en;
  assign rhy_kon = r_rhy_kon;
endmodule

// File: tb/tb_jtopll_wrsched.sv
// tb_jtopll_wrsched: random and directed CPU writes checked against a queue-based model of
// the register map, with a strobe monitor that checks kind, target, data and hold length.
module tb_jtopll_wrsched;
  logic clk = 0, rst = 1, cen = 0, addr = 0, wr = 0, zero = 0;
  logic [7:0] din = 0;
  logic busy, ovf, up_fnumlo, up_fnumhi, up_inst, up_original, rhy_en;
  logic [7:0] reg_din;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic [4:0] rhy_kon;
  jtopll_wrsched dut (
    .clk(clk), .rst(rst), .cen(cen), .addr(addr), .din(din), .wr(wr), .busy(busy), .ovf(ovf),
    .zero(zero), .reg_din(reg_din), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst), .up_original(up_original),
    .rhy_en(rhy_en), .rhy_kon(rhy_kon)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_s;
  wr_s expq[$];
  logic m_en = 0;
  logic [4:0] m_kon = 0;
  // 0 discard, 1 patch, 2 rhythm, 3 fnumlo, 4 fnumhi, 5 inst
  function automatic int kind(input logic [7:0] a);
    int hi = a / 16;
    int lo = a % 16;
    if (a < 8) return 1;
    if (a == 8'h0E) return 2;
    if (hi >= 1 && hi <= 3 && lo <= 8) return 2 + hi;
    return 0;
  endfunction
  task automatic drain();
    while (expq.size() > 0 && kind(expq[0].a) inside {0, 2}) begin
      if (kind(expq[0].a) == 2) begin
        m_en = expq[0].d[5];
        m_kon = expq[0].d[4:0];
      end
      void'(expq.pop_front());
    end
  endtask
  // strobe monitor
  logic act = 0, bad = 0, prev_cz = 0;
  int hi_clk, hi_cen, k, eg, es;
  wr_s cur;
  logic [3:0] emask, m_up;
  always @(negedge clk) begin
    m_up = {up_original, up_inst, up_fnumhi, up_fnumlo};
    if (rst) begin
      act = 0;
      prev_cz = 0;
    end else begin
      if (!act && m_up != 0) begin
        act = 1;
        bad = 0;
        hi_clk = 0;
        hi_cen = 0;
        drain();
        if (expq.size() == 0) begin
          chk("unexpected_strobe", m_up, 0);
          act = 0;
        end else begin
          cur = expq.pop_front();
          k = kind(cur.a);
          emask = k == 1 ? 4'b1000 : 4'(1 << (k - 3));
          eg = k == 1 ? 0 : (cur.a % 16) / 3;
          es = k == 1 ? cur.a % 8 : (cur.a % 16) % 3;
          chk("strobe_kind", m_up, emask);
          chk("reg_din", reg_din, cur.d);
          chk("sel_group", sel_group, eg);
          chk("sel_sub", sel_sub, es);
          chk("rhy_at_strobe", {rhy_en, rhy_kon}, {m_en, m_kon});
          if (k >= 3) chk("start_on_zero", prev_cz, 1);
        end
      end
      if (act) begin
        if (m_up == 0) begin
          act = 0;
          chk("strobe_stable", bad, 0);
          chk("strobe_len", k == 1 ? hi_clk : hi_cen, k == 1 ? 1 : 18);
        end else begin
          hi_clk++;
          if (cen) hi_cen++;
          if (m_up !== emask || reg_din !== cur.d || sel_group !== 2'(eg) || sel_sub !== 3'(es)) bad = 1;
        end
      end
      prev_cz = cen && zero;
    end
  end
  // random slot clock enables with an 18-slot round
  initial begin
    int slot = 0;
    forever begin
      @(posedge clk);
      if (cen) slot = (slot + 1) % 18;
      #1;
      cen = $urandom_range(0, 2) == 0;
      zero = slot == 0;
    end
  end
  task automatic bus(input logic a, input logic [7:0] v);
    addr = a;
    din = v;
    wr = 1;
    @(posedge clk);
    #1 wr = 0;
  endtask
  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    bus(0, a);
    bus(1, d);
    expq.push_back('{a, d});
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  function automatic logic [7:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 8'($urandom_range(0, 7));
      1: return 8'h0E;
      2, 3, 4: return 8'(16 * $urandom_range(1, 3) + $urandom_range(0, 8));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction
  initial begin
    logic [7:0] d0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_up", {up_original, up_inst, up_fnumhi, up_fnumlo}, 0);
    chk("rst_rhy", {rhy_en, rhy_kon}, 0);
    chk("rst_reg_din", reg_din, 0);
    chk("rst_sel", {sel_group, sel_sub}, 0);
    @(posedge clk);
    #1 rst = 0;
    wr_reg(8'h10, 8'hAB);
    wait_idle();
    wr_reg(8'h27, 8'h15);
    wait_idle();
    wr_reg(8'h0E, 8'h3F);
    @(posedge clk);
    @(posedge clk);
    #1 chk("rhy_en_2clk", rhy_en, 1);
    chk("rhy_kon_2clk", rhy_kon, 5'h1F);
    chk("rhy_no_strobe", {up_original, up_inst, up_fnumhi, up_fnumlo}, 0);
    wait_idle();
    wr_reg(8'h05, 8'h77);
    wait_idle();
    wr_reg(8'h19, 8'($urandom));
    @(posedge clk);
    @(posedge clk);
    #1 chk("discard_19_busy", busy, 0);
    wr_reg(8'h0F, 8'($urandom));
    @(posedge clk);
    @(posedge clk);
    #1 chk("discard_0f_busy", busy, 0);
    repeat (25) begin
      repeat ($urandom_range(1, 4)) wr_reg(rnd_addr(), 8'($urandom));
      wait_idle();
    end
    drain();
    chk("rnd_rhy", {rhy_en, rhy_kon}, {m_en, m_kon});
    chk("rnd_leftover", expq.size(), 0);
    chk("rnd_ovf", ovf, 0);
    // overflow while a channel strobe is held, then reset mid-apply
    wr_reg(8'h0E, 8'h25);
    wr_reg(8'h12, 8'h5A);
    n = 0;
    while (!up_fnumlo && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("apply_seen", up_fnumlo, 1);
    d0 = 8'($urandom_range(0, 200));
    bus(0, 8'h33);
    for (int i = 0; i < 5; i++) begin
      bus(1, d0 + 8'(i));
      if (i < 4) expq.push_back('{8'h33, d0 + 8'(i)});
    end
    chk("ovf_set", ovf, 1);
    chk("ovf_busy", busy, 1);
    n = 0;
    while (!(act && cur.d == d0 + 8'd1) && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("second_queued_seen", act && cur.d == d0 + 8'd1, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    expq.delete();
    m_en = 0;
    m_kon = 0;
    @(negedge clk);
    chk("rst_mid_up", {up_original, up_inst, up_fnumhi, up_fnumlo}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_rhy_en", rhy_en, 0);
    @(posedge clk);
    #1 wr_reg(8'h31, 8'h44);
    wait_idle();
    chk("final_leftover", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
